// File: rtl/idma_init_pattern_read.sv
// iDMA INIT read side: synthesises constant, incrementing or LFSR pattern beats
// and pushes them byte-wise into the dataflow buffer, one response per beat.
module idma_init_pattern_read #(
  parameter int unsigned StrbWidth   = 16,
  parameter int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               read_meta_mode_i,
  input  logic [31:0]              read_meta_seed_i,
  input  logic [7:0]               read_meta_len_i,
  input  logic                     read_meta_valid_i,
  output logic                     read_meta_ready_o,
  input  logic [OffsetWidth-1:0]   r_dp_offset_i,
  input  logic [OffsetWidth-1:0]   r_dp_tailer_i,
  input  logic [OffsetWidth-1:0]   r_dp_shift_i,
  input  logic                     r_dp_valid_i,
  output logic                     r_dp_ready_o,
  input  logic                     dp_poison_i,
  output logic                     r_dp_rsp_err_o,
  output logic                     r_dp_rsp_last_o,
  output logic                     r_dp_rsp_valid_o,
  input  logic                     r_dp_rsp_ready_i,
  output logic [8*StrbWidth-1:0]   buffer_in_o,
  output logic [StrbWidth-1:0]     buffer_in_valid_o,
  input  logic [StrbWidth-1:0]     buffer_in_ready_i
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;
  localparam logic [OffsetWidth:0] StrbW = (OffsetWidth+1)'(StrbWidth);

  state_e                 state_r, state_d;
  logic [1:0]             mode_r;
  logic [7:0]             cnt_r;
  logic                   err_r;
  logic [31:0]            pat_cnt_r;
  logic [31:0]            lfsr_r;
  logic                   rsp_valid_r;
  logic                   rsp_err_r;
  logic                   rsp_last_r;

  logic [StrbWidth-1:0]   ones_s;
  logic [OffsetWidth:0]   tail_sh_s;
  logic [OffsetWidth:0]   rot_inv_s;
  logic [StrbWidth-1:0]   mask_s;
  logic [StrbWidth-1:0]   rmask_s;
  logic [8*StrbWidth-1:0] data_s;
  logic [8*StrbWidth-1:0] rot_data_s;
  logic [OffsetWidth:0]   pop_s;
  logic [31:0]            lfsr_next_s;
  logic                   meta_fire_s;
  logic                   slot_free_s;
  logic                   offer_s;
  logic                   fire_s;

  // Byte window of the current beat and its rotated image in the buffer.
  always_comb begin
    ones_s    = '1;
    tail_sh_s = StrbW - {1'b0, r_dp_tailer_i};
    rot_inv_s = StrbW - {1'b0, r_dp_shift_i};
    if (r_dp_tailer_i != '0) begin
      mask_s = (ones_s << r_dp_offset_i) & (ones_s >> tail_sh_s);
    end else begin
      mask_s = ones_s << r_dp_offset_i;
    end
    // A shift by the full width yields zero, so shift==0 degenerates cleanly.
    rmask_s = (mask_s << r_dp_shift_i) | (mask_s >> rot_inv_s);
  end

  // Pre-rotation pattern bytes and the mask population count.
  always_comb begin
    data_s = '0;
    pop_s  = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      pop_s = pop_s + {{OffsetWidth{1'b0}}, mask_s[i]};
      if (mask_s[i]) begin
        case (mode_r)
          2'd0:    data_s[i*8 +: 8] = pat_cnt_r[7:0];
          2'd1:    data_s[i*8 +: 8] = pat_cnt_r[7:0] + 8'(i) - 8'(r_dp_offset_i);
          2'd2:    data_s[i*8 +: 8] = lfsr_r[8*(i%4) +: 8];
          default: data_s[i*8 +: 8] = 8'h00;
        endcase
      end else begin
        data_s[i*8 +: 8] = 8'h00;
      end
    end
    rot_data_s  = (data_s << {r_dp_shift_i, 3'b000}) | (data_s >> {rot_inv_s, 3'b000});
    lfsr_next_s = {1'b0, lfsr_r[31:1]} ^ (lfsr_r[0] ? LfsrTaps : 32'h0000_0000);
  end

  // Handshake qualification; buffer valid never looks at buffer ready.
  always_comb begin
    meta_fire_s       = (state_r == IDLE) && read_meta_valid_i;
    slot_free_s       = !rsp_valid_r || r_dp_rsp_ready_i;
    offer_s           = (state_r == ACTIVE) && r_dp_valid_i && slot_free_s;
    fire_s            = offer_s && ((buffer_in_ready_i & rmask_s) == rmask_s);
    read_meta_ready_o = (state_r == IDLE);
    r_dp_ready_o      = fire_s;
    buffer_in_valid_o = offer_s ? rmask_s : '0;
    if ((state_r == ACTIVE) && !dp_poison_i) begin
      buffer_in_o = rot_data_s;
    end else begin
      buffer_in_o = '0;
    end
    r_dp_rsp_valid_o = rsp_valid_r;
    r_dp_rsp_err_o   = rsp_err_r;
    r_dp_rsp_last_o  = rsp_last_r;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (meta_fire_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (fire_s && (cnt_r == 8'd0)) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Burst context: mode, beat counter and pattern generators.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_r    <= 2'd0;
      cnt_r     <= 8'd0;
      err_r     <= 1'b0;
      pat_cnt_r <= 32'd0;
      lfsr_r    <= 32'd1;
    end else if (meta_fire_s) begin
      mode_r    <= read_meta_mode_i;
      cnt_r     <= read_meta_len_i;
      err_r     <= (read_meta_mode_i == 2'd3);
      pat_cnt_r <= read_meta_seed_i;
      lfsr_r    <= (read_meta_seed_i == 32'd0) ? 32'd1 : read_meta_seed_i;
    end else if (fire_s) begin
      if (mode_r == 2'd1) begin
        pat_cnt_r <= pat_cnt_r + 32'(pop_s);
      end
      if (mode_r == 2'd2) begin
        lfsr_r <= lfsr_next_s;
      end
      if (cnt_r != 8'd0) begin
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

  // Single-entry response register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_last_r  <= 1'b0;
    end else if (fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= err_r;
      rsp_last_r  <= (cnt_r == 8'd0);
    end else if (rsp_valid_r && r_dp_rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idma_init_pattern_read.sv
// Randomised and directed bench for idma_init_pattern_read against a lane-level
// reference model of the pattern source.
module tb_idma_init_pattern_read;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    meta_mode;
  logic [31:0]   meta_seed;
  logic [7:0]    meta_len;
  logic          meta_valid;
  logic          meta_ready;
  logic [3:0]    offset, tailer, shift;
  logic          dp_valid;
  logic          dp_ready;
  logic          poison;
  logic          rsp_err, rsp_last, rsp_valid;
  logic          rsp_ready;
  logic [8*N-1:0] bdata;
  logic [N-1:0]  bvalid;
  logic [N-1:0]  bready;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_active;
  logic [1:0]  m_mode;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_pat;
  logic [31:0] m_lfsr;
  bit          m_rv, m_re, m_rl;

  always #5 clk = ~clk;

  idma_init_pattern_read #(.StrbWidth(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .read_meta_mode_i(meta_mode), .read_meta_seed_i(meta_seed),
    .read_meta_len_i(meta_len), .read_meta_valid_i(meta_valid),
    .read_meta_ready_o(meta_ready),
    .r_dp_offset_i(offset), .r_dp_tailer_i(tailer), .r_dp_shift_i(shift),
    .r_dp_valid_i(dp_valid), .r_dp_ready_o(dp_ready),
    .dp_poison_i(poison),
    .r_dp_rsp_err_o(rsp_err), .r_dp_rsp_last_o(rsp_last),
    .r_dp_rsp_valid_o(rsp_valid), .r_dp_rsp_ready_i(rsp_ready),
    .buffer_in_o(bdata), .buffer_in_valid_o(bvalid), .buffer_in_ready_i(bready)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_mode = 2'd0; m_cnt = 0; m_err = 1'b0;
    m_pat = 32'd0; m_lfsr = 32'd1; m_rv = 1'b0; m_re = 1'b0; m_rl = 1'b0;
  endtask

  // Lane j of the buffer holds pre-rotation byte (j - shift) mod N.
  task automatic model_lanes(output logic [N-1:0] rm, output logic [8*N-1:0] dat, output int pop);
    rm = '0; dat = '0; pop = 0;
    for (int j = 0; j < N; j++) begin
      int i;
      bit inm;
      logic [7:0] v;
      i   = (j - int'(shift) + N) % N;
      inm = (i >= int'(offset)) && (tailer == 4'd0 || i < int'(tailer));
      case (m_mode)
        2'd0:    v = m_pat[7:0];
        2'd1:    v = m_pat[7:0] + 8'(i) - 8'(offset);
        2'd2:    v = 8'((m_lfsr >> (8 * (i % 4))) & 32'hFF);
        default: v = 8'h00;
      endcase
      if (inm) begin
        rm[j] = 1'b1;
        pop++;
        dat[j*8 +: 8] = poison ? 8'h00 : v;
      end
    end
  endtask

  function automatic bit model_fire(input logic [N-1:0] rm);
    return m_active && dp_valid && (!m_rv || rsp_ready) && ((bready & rm) == rm);
  endfunction

  task automatic model_check();
    logic [N-1:0] rm;
    logic [8*N-1:0] dat;
    int pop;
    bit offer;
    model_lanes(rm, dat, pop);
    offer = m_active && dp_valid && (!m_rv || rsp_ready);
    chk("meta_ready", 128'(meta_ready), 128'(!m_active));
    chk("dp_ready", 128'(dp_ready), 128'(model_fire(rm)));
    chk("buf_valid", 128'(bvalid), offer ? 128'(rm) : 128'd0);
    if (offer) chk("buf_data", bdata, dat);
    chk("rsp_valid", 128'(rsp_valid), 128'(m_rv));
    if (m_rv) begin
      chk("rsp_err", 128'(rsp_err), 128'(m_re));
      chk("rsp_last", 128'(rsp_last), 128'(m_rl));
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rm;
    logic [8*N-1:0] dat;
    int pop;
    bit fire;
    if (rst) begin
      model_reset();
    end else begin
      model_lanes(rm, dat, pop);
      fire = model_fire(rm);
      if (fire) begin
        m_rv = 1'b1; m_re = m_err; m_rl = (m_cnt == 0);
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
      end
      if (!m_active && meta_valid) begin
        m_active = 1'b1; m_mode = meta_mode; m_cnt = int'(meta_len);
        m_err = (meta_mode == 2'd3); m_pat = meta_seed;
        m_lfsr = (meta_seed == 32'd0) ? 32'd1 : meta_seed;
      end else if (fire) begin
        if (m_mode == 2'd1) m_pat = m_pat + 32'(pop);
        if (m_mode == 2'd2) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'd0);
        if (m_cnt == 0) m_active = 1'b0;
        else m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic meta(input logic [1:0] md, input logic [31:0] sd, input logic [7:0] ln);
    meta_mode = md; meta_seed = sd; meta_len = ln; meta_valid = 1'b1; dp_valid = 1'b0;
    sample();
    chk("meta_accept", 128'(meta_ready), 128'd1);
    advance();
    meta_valid = 1'b0;
  endtask

  task automatic set_beat(input logic [3:0] o, input logic [3:0] t, input logic [3:0] s);
    offset = o; tailer = t; shift = s; dp_valid = 1'b1;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_meta_ready"}, 128'(meta_ready), 128'd1);
    chk({tag, "_dp_ready"}, 128'(dp_ready), 128'd0);
    chk({tag, "_bvalid"}, 128'(bvalid), 128'd0);
    chk({tag, "_bdata"}, bdata, 128'd0);
    chk({tag, "_rsp"}, {125'd0, rsp_valid, rsp_err, rsp_last}, 128'd0);
  endtask

  initial begin
    rst = 1'b1; meta_mode = 2'd0; meta_seed = 32'd0; meta_len = 8'd0; meta_valid = 1'b0;
    offset = 4'd0; tailer = 4'd0; shift = 4'd0; dp_valid = 1'b0; poison = 1'b0;
    rsp_ready = 1'b1; bready = '1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // constant pattern, single full beat
    meta(2'd0, 32'h0000_00A5, 8'd0);
    set_beat(4'd0, 4'd0, 4'd0);
    sample();
    chk("m0_data", bdata, {16{8'hA5}});
    chk("m0_valid", 128'(bvalid), 128'hFFFF);
    chk("m0_fire", 128'(dp_ready), 128'd1);
    advance();
    dp_valid = 1'b0;
    sample();
    chk("m0_rsp", {125'd0, rsp_valid, rsp_last, rsp_err}, 128'b110);
    chk("m0_idle", 128'(meta_ready), 128'd1);
    advance();

    // incrementing pattern across two beats, wrapping through 0xFF
    meta(2'd1, 32'h0000_00FE, 8'd1);
    set_beat(4'd14, 4'd0, 4'd0);
    sample();
    chk("m1_b0_lanes", 128'(bdata[127:112]), 128'hFFFE);
    chk("m1_b0_valid", 128'(bvalid), 128'hC000);
    advance();
    set_beat(4'd0, 4'd0, 4'd0);
    sample();
    chk("m1_b0_last", 128'(rsp_last), 128'd0);
    chk("m1_b1_lane0", 128'(bdata[7:0]), 128'h00);
    chk("m1_b1_lane15", 128'(bdata[127:120]), 128'h0F);
    advance();
    dp_valid = 1'b0;
    sample();
    chk("m1_b1_last", 128'(rsp_last), 128'd1);
    advance();

    // LFSR with zero seed
    meta(2'd2, 32'd0, 8'd1);
    set_beat(4'd0, 4'd0, 4'd0);
    sample();
    chk("m2_b0", bdata, {4{32'h0000_0001}});
    advance();
    sample();
    chk("m2_b1", 128'(bdata[31:0]), 128'h8020_0003);
    advance();
    dp_valid = 1'b0;

    // rotated partial window
    meta(2'd1, 32'h0000_0010, 8'd0);
    set_beat(4'd0, 4'd4, 4'd3);
    sample();
    chk("rot_valid", 128'(bvalid), 128'h0078);
    chk("rot_lane3", 128'(bdata[31:24]), 128'h10);
    chk("rot_lane0", 128'(bdata[7:0]), 128'h00);
    advance();
    dp_valid = 1'b0;

    // buffer back-pressure on a single lane
    meta(2'd0, 32'h0000_0033, 8'd0);
    bready = 16'hFFDF;
    set_beat(4'd0, 4'd0, 4'd0);
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("bp_stall", 128'(dp_ready), 128'd0);
      chk("bp_valid", 128'(bvalid), 128'hFFFF);
      advance();
    end
    bready = '1;
    sample();
    chk("bp_release", 128'(dp_ready), 128'd1);
    advance();
    dp_valid = 1'b0;

    // response back-pressure then reset mid-burst
    meta(2'd1, 32'd0, 8'd1);
    rsp_ready = 1'b0;
    set_beat(4'd0, 4'd0, 4'd0);
    sample();
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rsp_stall", 128'(dp_ready), 128'd0);
      chk("rsp_held", 128'(rsp_valid), 128'd1);
      advance();
    end
    #2;
    rst = 1'b1;
    #1;
    idle_outputs("midrst");
    model_reset();
    dp_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      int t;
      rst        = ($urandom_range(0, 499) == 0);
      if (rst) begin
        #1;
        model_reset();
      end
      meta_valid = ($urandom_range(0, 3) == 0);
      meta_mode  = 2'($urandom_range(0, 3));
      meta_seed  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      meta_len   = 8'($urandom_range(0, 3));
      t          = $urandom_range(0, 15);
      tailer     = 4'(t);
      offset     = 4'($urandom_range(0, (t == 0) ? 15 : t - 1));
      shift      = 4'($urandom_range(0, 15));
      dp_valid   = ($urandom_range(0, 3) != 0);
      poison     = ($urandom_range(0, 7) == 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      bready     = ($urandom_range(0, 3) != 0) ? 16'hFFFF : 16'($urandom);
      sample();
      advance();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idma_init_pattern_read.md
Name: idma_init_pattern_read

Overview:
- Read-side source of the iDMA INIT protocol: generates pattern data (constant, incrementing, pseudo-random) instead of reading memory.
- Pushes data byte-wise into the dataflow buffer that the INIT write stage drains.
- Accepts one meta request per burst and one read-datapath request per beat; returns one per-beat response to the read datapath.

Parameters:
- StrbWidth, 16, bus width in bytes; power of two, ≥4.
- OffsetWidth, $clog2(StrbWidth), width of the offset/tailer/shift fields.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- read_meta_mode_i  in  2  0 constant, 1 incrementing, 2 LFSR, 3 illegal.
- read_meta_seed_i  in  32  initial pattern value.
- read_meta_len_i  in  8  beats-1 of burst.
- read_meta_valid_i / read_meta_ready_o  in/out  1  meta handshake.
- r_dp_offset_i, r_dp_tailer_i, r_dp_shift_i  in  OffsetWidth  per-beat byte window and buffer rotation.
- r_dp_valid_i / r_dp_ready_o  in/out  1  beat handshake.
- dp_poison_i  in  1  forces emitted data to zero.
- r_dp_rsp_err_o, r_dp_rsp_last_o  out  1  response payload.
- r_dp_rsp_valid_o / r_dp_rsp_ready_i  out/in  1  response handshake.
- buffer_in_o  out  8*StrbWidth  byte data to buffer.
- buffer_in_valid_o  out  StrbWidth  per-byte valid.
- buffer_in_ready_i  in  StrbWidth  per-byte ready.

Behaviour:
- States: IDLE, ACTIVE.
- read_meta_ready_o = (state==IDLE).
- Meta handshake in IDLE:
  - Latch mode, beat counter = len, err = (mode==3).
  - pat_cnt = seed. For mode 2, lfsr = seed, or 32'h1 if seed==0.
  - Go to ACTIVE next cycle.
- Beat mask:
  - mask = ('1<<offset) & (tailer!=0 ? '1>>(StrbWidth-tailer) : '1).
  - rmask = mask rotated left by shift.
- Beat fires when all hold:
  - state==ACTIVE and r_dp_valid_i.
  - (buffer_in_ready_i & rmask)==rmask.
  - Response register empty, or drained this cycle.
- Outputs tied to beat firing:
  - r_dp_ready_o = fire.
  - buffer_in_valid_o = rmask when ACTIVE & r_dp_valid_i & response slot free, else 0.
  - Valid must not depend on buffer_in_ready_i (no combinational loop).
- Pre-rotation byte i, lanes outside mask = 0:
  - mode 0: seed[7:0].
  - mode 1: (pat_cnt + i - offset) mod 256.
  - mode 2: lfsr[8*(i%4)+:8].
  - mode 3: 0.
  - The data vector is rotated left by shift bytes; buffer_in_o = rotated data.
  - dp_poison_i=1 forces buffer_in_o=0; handshakes are unaffected.
- On fire:
  - mode 1: pat_cnt += popcount(mask).
  - mode 2: lfsr steps one Galois shift, taps 32'h80200003.
  - Response register loads err_o = err, last_o = (beat counter==0).
  - If beat counter==0, go to IDLE; else decrement the counter.
- Response register is 1 entry:
  - r_dp_rsp_valid_o is registered; cleared on rsp ready & valid unless reloaded the same cycle.
  - The last response may still be pending after returning to IDLE; the next meta is accepted regardless.
- Reset (async, any time) clears:
  - state → IDLE, counters, lfsr → 1, response valid, err.
  - All outputs 0 except read_meta_ready_o = 1.
  - In-flight burst is abandoned, no response.
- Boundaries:
  - tailer==0 means the full upper range.
  - offset=0 with tailer=0 gives a full mask.
  - Counter and pattern wrap mod 2^8 / 2^32 without error.
  - mask==0 cannot occur by contract; the design need not handle it.

Test Plan:
- Mode 0, seed 0xA5, len 0, offset 0, tailer 0, shift 0, ready all-ones -> one cycle with valid=16'hFFFF, all bytes 0xA5; rsp last=1 err=0; back to IDLE.
- Mode 1, seed 0xFE, len 1:
  - beat0 offset 14 -> lanes 14,15 = 0xFE,0xFF.
  - beat1 offset 0 -> lane0=0x00 … lane15=0x0F; last on beat1 only.
- Mode 2, seed 0 -> lfsr loaded 1; beat0 bytes {01,00,00,00} repeated; beat1 uses the stepped state 0x80200003 per the Galois rule.
- Shift 3, offset 0, tailer 4 -> buffer_in_valid_o = 16'h0078; data byte0 appears at lane 3.
- buffer_in_ready_i lacks lane 5 of rmask -> no fire, counters frozen, valid held; ready restored -> single fire.
- r_dp_rsp_ready_i low for 3 cycles -> second beat stalls; assert rst_i mid-burst -> all outputs cleared and read_meta_ready_o=1 within the same cycle.
